// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and big-endian types for the 64x32 register file
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [0:ADDR_W-1] reg_addr_t;
  typedef logic [0:DATA_W-1] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port: R0 forced to zero, then write bypass, then stored value
module regfile_read_port
  import regfile_pkg::*;
(
  input  reg_addr_t addr,
  input  reg_data_t stored,
  input  logic      reset,
  input  logic      regwe,
  input  reg_addr_t Rw,
  input  reg_data_t Din,
  output reg_data_t dout
);

  // R0 check comes first so a write aimed at R0 can never leak through the bypass
  always_comb begin
    dout = stored;
    if (addr == '0) begin
      dout = '0;
    end else if (regwe && reset && (Rw == addr)) begin
      dout = Din;
    end
  end

endmodule

// File: rtl/regfile_64x32.sv
// rtl/regfile_64x32.sv - 64x32 register file, two async read ports with bypass, one sync write port
module regfile_64x32
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      regwe,
  input  reg_addr_t Rw,
  input  reg_addr_t Ra,
  input  reg_addr_t Rb,
  input  reg_data_t Din,
  output reg_data_t regout1,
  output reg_data_t regout2
);

  reg_data_t regs [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (regwe && (Rw != '0)) begin
      regs[Rw] <= Din;
    end
  end

  regfile_read_port u_port_a (
    .addr   (Ra),
    .stored (regs[Ra]),
    .reset  (reset),
    .regwe  (regwe),
    .Rw     (Rw),
    .Din    (Din),
    .dout   (regout1)
  );

  regfile_read_port u_port_b (
    .addr   (Rb),
    .stored (regs[Rb]),
    .reset  (reset),
    .regwe  (regwe),
    .Rw     (Rw),
    .Din    (Din),
    .dout   (regout2)
  );

endmodule

// File: tb/tb_regfile_64x32.sv
// tb/tb_regfile_64x32.sv - directed vector table plus randomized run against an array model
module tb_regfile_64x32;

  logic        clk;
  logic        reset;
  logic        regwe;
  logic [0:5]  Rw;
  logic [0:5]  Ra;
  logic [0:5]  Rb;
  logic [0:31] Din;
  logic [0:31] regout1;
  logic [0:31] regout2;

  int checks = 0;
  int errors = 0;

  regfile_64x32 dut (
    .clk     (clk),
    .reset   (reset),
    .regwe   (regwe),
    .Rw      (Rw),
    .Ra      (Ra),
    .Rb      (Rb),
    .Din     (Din),
    .regout1 (regout1),
    .regout2 (regout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [5:0]  rw;
    logic [5:0]  ra;
    logic [5:0]  rb;
    logic [31:0] din;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] model [64];

  function automatic void add(logic rst, logic we, logic [5:0] rw, logic [5:0] ra,
                              logic [5:0] rb, logic [31:0] din, logic [31:0] e1, logic [31:0] e2);
    vec_t v;
    v.rst = rst; v.we = we; v.rw = rw; v.ra = ra; v.rb = rb;
    v.din = din; v.e1 = e1; v.e2 = e2;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(logic rst, logic we, logic [5:0] rw, logic [5:0] ra,
                       logic [5:0] rb, logic [31:0] din);
    reset = rst; regwe = we; Rw = rw; Ra = ra; Rb = rb; Din = din;
  endtask

  initial begin
    logic [31:0] e1, e2;
    logic        rst, we;
    logic [5:0]  rw, ra, rb;
    logic [31:0] din;

    apply(1'b0, 1'b0, 6'd0, 6'd1, 6'd5, 32'h0);
    #12;
    chk("reset_out1", regout1, 32'h0);
    chk("reset_out2", regout2, 32'h0);
    @(posedge clk); #1;

    add(1, 1,  1,  1,  0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000);
    add(1, 0,  1,  1,  1, 32'hBAADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    add(1, 0,  1,  2,  1, 32'hBAADBEEF, 32'h00000000, 32'hDEADBEEF);
    add(1, 1,  1,  2,  1, 32'hBAADBEEF, 32'h00000000, 32'hBAADBEEF);
    add(1, 0,  1,  1,  1, 32'h00000000, 32'hBAADBEEF, 32'hBAADBEEF);
    add(1, 1,  0,  0,  1, 32'hFFFFFFFF, 32'h00000000, 32'hBAADBEEF);
    add(1, 0,  0,  0,  0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000);
    add(1, 1, 63, 63,  1, 32'h12345678, 32'h12345678, 32'hBAADBEEF);
    add(1, 1,  2, 63,  2, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF);
    add(1, 0,  2, 63,  2, 32'h00000000, 32'h12345678, 32'hDEADBEEF);
    add(1, 0,  2, 63, 63, 32'h00000000, 32'h12345678, 32'h12345678);
    add(0, 1,  3,  1, 63, 32'h55555555, 32'h00000000, 32'h00000000);
    add(1, 0,  3,  1,  3, 32'h00000000, 32'h00000000, 32'h00000000);

    // each row: drive just after an edge, check combinationally, then take one edge
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].we, tbl[i].rw, tbl[i].ra, tbl[i].rb, tbl[i].din);
      #1;
      chk($sformatf("vec%0d_out1", i), regout1, tbl[i].e1);
      chk($sformatf("vec%0d_out2", i), regout2, tbl[i].e2);
      @(posedge clk); #1;
    end

    for (int a = 0; a < 64; a++) model[a] = 32'h0;

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 31) != 0);
      we  = $urandom_range(0, 1);
      rw  = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
      ra  = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
      rb  = ($urandom_range(0, 2) == 0) ? ra : 6'($urandom_range(0, 63));
      din = $urandom();
      apply(rst, we, rw, ra, rb, din);
      if (!rst) begin
        for (int a = 0; a < 64; a++) model[a] = 32'h0;
      end
      e1 = (ra == 0) ? 32'h0 : (we && rst && rw == ra) ? din : model[ra];
      e2 = (rb == 0) ? 32'h0 : (we && rst && rw == rb) ? din : model[rb];
      #1;
      chk("rand_out1", regout1, e1);
      chk("rand_out2", regout2, e2);
      @(posedge clk); #1;
      if (rst && we && rw != 0) model[rw] = din;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
